// File: rtl/vga_framebuffer_fetch.sv
// Scaled 128x96 RGB444 framebuffer feeding the 1024x768 VGA driver.
// Fetches two pixels ahead of posX/posY; one write port shared with a fill engine.
module vga_framebuffer_fetch #(
    parameter int          FB_W        = 128,
    parameter int          FB_H        = 96,
    parameter int          SCALE_SHIFT = 3,
    parameter int          H_VISIBLE   = 1024,
    parameter int          V_VISIBLE   = 768,
    parameter int          H_PERIOD    = 1329,
    parameter int          V_PERIOD    = 807,
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] posX,
    input  logic [11:0] posY,
    output logic [11:0] pixel_out,
    input  logic        wr_en,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [11:0] wr_data,
    output logic        wr_drop,
    input  logic        clear_req,
    output logic        busy
);
    localparam int DEPTH  = FB_W * FB_H;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clrCnt;
    logic [ADDR_W-1:0] rdAddr;
    logic [ADDR_W-1:0] memAddr;
    logic [11:0]       memData;
    logic [11:0]       rdData;
    logic              memWe;
    logic              wrOk;
    logic              clearStart;
    logic              vis0;
    logic              vis1;
    int                lx;
    int                ly;

    logic [11:0] mem [DEPTH];

    // Look-ahead by two driver counts, following the driver's line and frame wrap.
    always_comb begin
        lx = int'(posX) + 2;
        ly = int'(posY);
        if (int'(posX) >= H_PERIOD - 2) begin
            lx = int'(posX) + 2 - H_PERIOD;
            ly = int'(posY) + 1;
        end
        if (ly == V_PERIOD) ly = 0;
        vis0   = (lx < H_VISIBLE) && (ly < V_VISIBLE);
        rdAddr = ADDR_W'((ly >>> SCALE_SHIFT) * FB_W + (lx >>> SCALE_SHIFT));
    end

    assign clearStart = (state == IDLE) && clear_req;
    // The state term covers the one cycle where the fill has started but busy has not risen yet.
    assign wrOk = wr_en && !busy && (state == IDLE) && !clearStart
                  && (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
    assign memWe   = !rst && ((state == CLEAR) || wrOk);
    assign memAddr = (state == CLEAR) ? clrCnt : ADDR_W'(int'(wr_y) * FB_W + int'(wr_x));
    assign memData = (state == CLEAR) ? CLEAR_COLOR : wr_data;

    // Read-first RAM: a same-edge write is not seen by the read issued on that edge.
    always_ff @(posedge clk) begin
        if (memWe) mem[memAddr] <= memData;
        rdData <= mem[rdAddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clrCnt    <= '0;
            busy      <= 1'b0;
            wr_drop   <= 1'b0;
            vis1      <= 1'b0;
            pixel_out <= 12'h000;
        end else begin
            busy      <= (state == CLEAR);
            wr_drop   <= wr_en && !wrOk;
            vis1      <= vis0;
            pixel_out <= vis1 ? rdData : 12'h000;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state  <= CLEAR;
                        clrCnt <= '0;
                    end
                end
                CLEAR: begin
                    clrCnt <= clrCnt + 1'b1;
                    if (clrCnt == LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_framebuffer_fetch.sv
// Scoreboard bench: expected pixels are queued when a fetch is issued and
// compared when they reach pixel_out; write/clear behaviour checked inline.
module tb_vga_framebuffer_fetch;
    localparam int          FB_W = 128;
    localparam int          FB_H = 96;
    localparam int          HP   = 1329;
    localparam int          VP   = 807;
    localparam logic [11:0] CLR  = 12'h00F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] posX = '0;
    logic [11:0] posY = '0;
    logic [11:0] pixel_out;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_x = '0;
    logic [6:0]  wr_y = '0;
    logic [11:0] wr_data = '0;
    logic        wr_drop;
    logic        clear_req = 1'b0;
    logic        busy;

    vga_framebuffer_fetch #(.CLEAR_COLOR(CLR)) dut (
        .clk(clk), .rst(rst), .posX(posX), .posY(posY), .pixel_out(pixel_out),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_drop(wr_drop), .clear_req(clear_req), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [11:0] exp;
    } sbEnt_t;

    sbEnt_t      sb[$];
    logic [11:0] model [FB_W*FB_H];
    bit          known [FB_W*FB_H];
    int          nTests = 0;
    int          nFail  = 0;
    int          curX = 0;
    int          curY = 0;
    bit          chkEn = 1'b1;
    bit          wrModel = 1'b0;
    int          cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver counter: one step of the X/Y raster counter.
    task automatic adv(inout int x, inout int y);
        x++;
        if (x == HP) begin
            x = 0;
            y++;
            if (y == VP) y = 0;
        end
    endtask

    task automatic step();
        int tx;
        int ty;
        int a;
        sbEnt_t e;
        tx = curX;
        ty = curY;
        posX = 12'(curX);
        posY = 12'(curY);
        adv(tx, ty);
        adv(tx, ty);
        if (tx < 1024 && ty < 768) begin
            a = (ty / 8) * FB_W + tx / 8;
            e.chk = chkEn && known[a];
            e.exp = model[a];
        end else begin
            e.chk = chkEn;
            e.exp = 12'h000;
        end
        sb.push_back(e);
        if (wrModel) begin
            a = int'(wr_y) * FB_W + int'(wr_x);
            model[a] = wr_data;
            known[a] = 1'b1;
        end
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            if (e.chk) chk("pix", 32'(pixel_out), 32'(e.exp));
        end
        adv(curX, curY);
    endtask

    task automatic seg(input int x, input int y, input int n);
        curX = x;
        curY = y;
        repeat (n) step();
    endtask

    task automatic doWrite(input int x, input int y, input logic [11:0] d, input bit expDrop);
        wr_en   = 1'b1;
        wr_x    = 8'(x);
        wr_y    = 7'(y);
        wr_data = d;
        wrModel = !expDrop;
        step();
        wr_en   = 1'b0;
        wrModel = 1'b0;
        chk("wr_drop", 32'(wr_drop), 32'(expDrop));
    endtask

    task automatic doReset();
        sbEnt_t e;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        chk("rst_pix", 32'(pixel_out), 0);
        chk("rst_drop", 32'(wr_drop), 0);
        rst = 1'b0;
        sb.delete();
        e.chk = 1'b1;
        e.exp = 12'h000;
        sb.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        doReset();
        // Contents unknown yet: only blanking must read zero.
        seg(1000, 5, 40);
        seg(1320, 767, 20);
        seg(500, 800, 10);

        // Full clear, with a repeated request and a blocked write mid-way.
        chkEn = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("busy_t0", 32'(busy), 0);
        step();
        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            cnt++;
            if (cnt == 5000) clear_req = 1'b1;
            if (cnt == 6000) doWrite(0, 0, 12'hABC, 1'b1);
            else step();
            clear_req = 1'b0;
        end
        chk("busy_len", 32'(cnt), 12288);
        for (int a = 0; a < FB_W*FB_H; a++) begin
            model[a] = CLR;
            known[a] = 1'b1;
        end
        chkEn = 1'b1;
        seg(0, 0, 30);
        seg(1320, 40, 40);
        seg(990, 767, 40);

        // Single pixel write, sampled around its 8x8 screen block.
        doWrite(5, 3, 12'hF0A, 1'b0);
        step();
        chk("drop_idle", 32'(wr_drop), 0);
        seg(28, 23, 26);
        seg(28, 24, 26);
        seg(28, 31, 26);
        seg(28, 32, 26);

        // Line and frame wrap of the look-ahead.
        doWrite(0, 1, 12'hABC, 1'b0);
        doWrite(0, 0, 12'h5A5, 1'b0);
        seg(1318, 10, 14);
        seg(1318, 806, 14);

        // Out-of-range X must not alias onto (0,2).
        doWrite(128, 1, 12'hEEE, 1'b1);
        step();
        chk("drop_pulse", 32'(wr_drop), 0);
        seg(1318, 15, 14);
        seg(1318, 12, 14);

        // Clear aborted by reset; write coinciding with the request is dropped.
        doWrite(98, 0, 12'h111, 1'b0);
        doWrite(99, 0, 12'h222, 1'b0);
        doWrite(100, 0, 12'h333, 1'b0);
        chkEn = 1'b0;
        clear_req = 1'b1;
        doWrite(0, 95, 12'h123, 1'b1);
        clear_req = 1'b0;
        repeat (99) step();
        chk("busy_mid", 32'(busy), 1);
        doReset();
        for (int a = 0; a < 99; a++) model[a] = CLR;
        chkEn = 1'b1;
        seg(780, 0, 32);
        seg(0, 0, 12);
        seg(1318, 765, 20);
        seg(0, 100, 4);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
